// File: rtl/fetch_stage.sv
// Instruction-fetch controller and IF/ID pipeline register for the pipelined MIPS core.
// Optional fetch-bubble counter is enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_cur,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   input  logic        stall,
   input  logic        flush,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] pc_next,
   output logic        pc_en,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] fetch_bubbles
`endif
);

   localparam logic [1:0] RST_HOLD = 2'd0;
   localparam logic [1:0] FETCH    = 2'd1;
   localparam logic [1:0] HOLD     = 2'd2;
   localparam logic [1:0] DISCARD  = 2'd3;

   logic [1:0]  state, state_nx;
   logic [31:0] hold_instr, hold_pc4;
   logic [31:0] pc4;
   logic        ld_mem, ld_hold, ld_bub, cap, empty;

   assign pc4     = pc_cur + 32'd4;
   assign pc_next = flush ? redirect_pc : pc4;

   always_comb begin
      state_nx = state;
      imem_req = 1'b0;
      pc_en    = 1'b0;
      ld_mem   = 1'b0;
      ld_hold  = 1'b0;
      ld_bub   = 1'b0;
      cap      = 1'b0;
      empty    = 1'b0;
      if (!rst) begin
         case (state)
            RST_HOLD: state_nx = FETCH;
            FETCH: begin
               imem_req = 1'b1;
               if (flush) begin
                  // a flush without a same-cycle response leaves a wrong-path word in flight
                  pc_en    = 1'b1;
                  ld_bub   = 1'b1;
                  state_nx = imem_ready ? FETCH : DISCARD;
               end else if (stall) begin
                  if (imem_ready) begin
                     cap      = 1'b1;
                     state_nx = HOLD;
                  end
               end else if (imem_ready) begin
                  ld_mem = 1'b1;
                  pc_en  = 1'b1;
               end else begin
                  ld_bub = 1'b1;
                  empty  = 1'b1;
               end
            end
            HOLD: begin
               if (flush) begin
                  pc_en    = 1'b1;
                  ld_bub   = 1'b1;
                  state_nx = FETCH;
               end else if (!stall) begin
                  ld_hold  = 1'b1;
                  pc_en    = 1'b1;
                  state_nx = FETCH;
               end
            end
            DISCARD: begin
               if (imem_ready) state_nx = FETCH;
               if (flush) begin
                  pc_en  = 1'b1;
                  ld_bub = 1'b1;
               end else if (!stall) begin
                  ld_bub = 1'b1;
                  empty  = 1'b1;
               end
            end
            default: state_nx = RST_HOLD;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RST_HOLD;
         hold_instr  <= '0;
         hold_pc4    <= '0;
         if_id_instr <= NOP_INSTR;
         if_id_pc4   <= '0;
         if_id_valid <= 1'b0;
      end else begin
         state <= state_nx;
         if (cap) begin
            hold_instr <= imem_rdata;
            hold_pc4   <= pc4;
         end
         if (ld_mem) begin
            if_id_instr <= imem_rdata;
            if_id_pc4   <= pc4;
            if_id_valid <= 1'b1;
         end else if (ld_hold) begin
            if_id_instr <= hold_instr;
            if_id_pc4   <= hold_pc4;
            if_id_valid <= 1'b1;
         end else if (ld_bub) begin
            if_id_instr <= NOP_INSTR;
            if_id_pc4   <= '0;
            if_id_valid <= 1'b0;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         fetch_bubbles <= '0;
      else if (empty && fetch_bubbles != 32'hFFFF_FFFF)
         fetch_bubbles <= fetch_bubbles + 32'd1;
   end
`endif

endmodule
